// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, result {rem, quo}.
// Ports: clk, rst, signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
//   result_o, ready_o, busy_o, div_by_zero_o.
// Optional: define DIV_ZERO_FLAG_EN for a registered div_by_zero_o flag.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  dvs;
  logic              neg_q;
  logic              neg_r;

  logic [WIDTH:0]    trial;
  logic [WIDTH:0]    diff;
  logic              take;
  logic [WIDTH-1:0]  rem_n;
  logic [WIDTH-1:0]  quo_n;
  logic [WIDTH-1:0]  q_fix;
  logic [WIDTH-1:0]  r_fix;
  logic [WIDTH-1:0]  mag1;
  logic [WIDTH-1:0]  mag2;
  logic              go;
  logic              last;

  assign go   = start_i && !annul_i;
  assign last = (cnt == CW'(WIDTH));

  // Trial is one bit wider so large divisors cannot lose the shifted-out bit.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvs};
    take  = !diff[WIDTH];
    rem_n = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], take};
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_r ? -rem : rem;
    mag1  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_FREE: begin
        if (go)
          state_n = (opdata2_i == '0) ? S_BYZERO : S_ON;
      end
      S_BYZERO: state_n = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)
          state_n = S_FREE;
        else if (last)
          state_n = S_END;
      end
      S_END: begin
        if (!start_i)
          state_n = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        S_FREE: begin
          if (go && opdata2_i != '0) begin
            cnt   <= '0;
            quo   <= mag1;
            rem   <= '0;
            dvs   <= mag2;
            neg_q <= signed_div_i &&
                     (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r <= signed_div_i && opdata1_i[WIDTH-1];
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            if (!last) begin
              rem <= rem_n;
              quo <= quo_n;
              cnt <= cnt + CW'(1);
            end else begin
              result_o <= {r_fix, q_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o = (state == S_ON) || (state == S_BYZERO);

`ifdef DIV_ZERO_FLAG_EN
  logic dz_q;

  always_ff @(posedge clk) begin
    if (rst)
      dz_q <= 1'b0;
    else if (state == S_BYZERO)
      dz_q <= !annul_i;
    else if (state == S_END && !start_i)
      dz_q <= 1'b0;
  end

  assign div_by_zero_o = dz_q;
`else
  assign div_by_zero_o = 1'b0;
`endif

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider; the execute stage is the initiator and this block is the responder for DIV/DIVU.
- The execute stage raises start_i, stalls the pipeline while busy, then writes result_o into HI/LO. HI takes the remainder, LO the quotient.
- Supports signed and unsigned division, divide-by-zero, and annulment on flush or exception.

Parameters:
- WIDTH, 32: operand width. result_o is 2*WIDTH. The iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled with start_i.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request. Held high by the initiator until it sees ready_o, then dropped.
- annul_i  in  1  cancel the in-flight operation (flush or exception).
- result_o  out  2*WIDTH  {remainder, quotient}. Registered.
- ready_o  out  1  result valid. Registered.
- busy_o  out  1  operation in progress; drives the execute-stage stall request.
- div_by_zero_o  out  1  divisor was zero (optional feature only).

Behaviour:
- Reset (rst=1 at an edge): state=FREE, result_o=0, ready_o=0, div_by_zero_o=0, counter=0. Reset mid-operation abandons the operation immediately.
- States: FREE, BYZERO, ON, END. busy_o = (state==ON or state==BYZERO), decoded from registered state.
- FREE:
  - start_i=1, annul_i=0, opdata2_i!=0: latch magnitudes, counter=0, go to ON.
  - Magnitudes: if signed_div_i and the operand MSB is set, store its two's complement; otherwise store it unchanged.
  - Also latch signed_div_i, the dividend sign and the divisor sign.
  - opdata2_i==0: go to BYZERO.
  - start_i=1 together with annul_i=1: ignored, stay in FREE.
- ON:
  - Each edge with counter<WIDTH: shift {rem, quo} left 1, bringing in the next dividend bit.
  - If rem >= divisor magnitude: rem -= divisor and the quotient LSB = 1; otherwise the LSB = 0. Then counter++.
  - Edge with counter==WIDTH: apply sign correction, load result_o, set ready_o=1, go to END.
  - Latency: ready_o is first high WIDTH+2 rising edges after the start edge (34 for WIDTH=32).
- Sign correction (signed only):
  - Quotient is negated if the latched signs differ.
  - Remainder takes the dividend's sign (negated if the dividend was negative).
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. No trap, no exception.
- BYZERO: the next edge loads result_o=0, sets ready_o=1, goes to END. Latency 2 edges after start.
- END:
  - Hold result_o and ready_o while start_i=1.
  - An edge with start_i=0 goes to FREE with ready_o=0 and result_o=0.
  - annul_i is ignored in END.
- Annul: annul_i=1 at an edge in ON or BYZERO goes to FREE with ready_o=0, result_o=0. No result is ever presented for an annulled operation.
- Simultaneous rst and annul_i: rst wins. Result is the same end state.
- Back-to-back operations: a new start is accepted only from FREE. start_i must be low for at least one edge in END.
- Inputs are not re-sampled after the start edge; changes to opdata*_i during ON have no effect.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined:
  - div_by_zero_o is a registered flag, set together with ready_o when the operation passed through BYZERO.
  - It clears when ready_o clears, on reset, or on annul.
- Undefined:
  - div_by_zero_o is tied to 0 and no flag register exists.
  - Divide-by-zero still returns result_o=0 with ready_o after 2 edges.

Test Plan:
- Unsigned 100/7: signed_div_i=0, opdata1=100, opdata2=7, start held.
  - Required: ready_o at the 34th edge, result_o={32'd2, 32'd14}, busy_o=1 during cycles 1..33.
- Signed -7/2: opdata1=0xFFFFFFF9, opdata2=2, signed.
  - Required: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 7/-2 and DIVU 0xFFFFFFF9/2:
  - Required: signed gives quotient 0xFFFFFFFD, remainder 1. Unsigned gives quotient 0x7FFFFFFC, remainder 1.
- Divide by zero: opdata2=0.
  - Required: ready_o after 2 edges, result_o=0.
  - With DIV_ZERO_FLAG_EN: div_by_zero_o=1, and 0 after start drops.
- Annul at iteration 10:
  - Required: next cycle FREE, busy_o=0, ready_o never asserts.
  - A new start of 9/3 then yields {0, 3} with full latency.
- Reset at iteration 20, and signed 0x80000000 / 0xFFFFFFFF:
  - Required: after rst all outputs are 0.
  - The overflow case returns {0, 0x80000000}.
